// File: rtl/hc_sync_fifo.sv
// Single-clock show-ahead FIFO with programmable almost-full/almost-empty thresholds,
// occupancy/credit counts, high-water mark, sticky overflow/underflow and synchronous flush.
module hc_sync_fifo #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned PW       = $clog2(DEPTH),
    localparam int unsigned CW       = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_enq_data,
    input  logic             i_enq_en,
    output logic             o_not_full,
    output logic [WIDTH-1:0] o_deq_data,
    input  logic             i_deq_en,
    output logic             o_not_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_count,
    output logic [CW-1:0]    o_free,
    output logic [CW-1:0]    o_high_water,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_high_water;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_enq_ok;
    logic             w_deq_ok;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_high_water_next;

    // Full/empty come from the occupancy count so pointers may wrap freely.
    assign w_full   = (r_count == DepthC);
    assign w_empty  = (r_count == '0);
    assign w_enq_ok = i_enq_en && !w_full && !i_flush;
    assign w_deq_ok = i_deq_en && !w_empty && !i_flush;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_enq_ok && !w_deq_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_enq_ok && w_deq_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        w_high_water_next = r_high_water;
        if (i_flush) begin
            w_high_water_next = '0;
        end else if (w_count_next > r_high_water) begin
            w_high_water_next = w_count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_high_water <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_high_water <= w_high_water_next;
            if (i_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_enq_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_deq_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
                if (i_enq_en && w_full) r_overflow <= 1'b1;
                if (i_deq_en && w_empty) r_underflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only accepted enqueues write it.
    always_ff @(posedge i_clk) begin
        if (w_enq_ok) r_mem[r_wr_ptr] <= i_enq_data;
    end

    assign o_deq_data     = r_mem[r_rd_ptr];
    assign o_not_full     = !w_full;
    assign o_not_empty    = !w_empty;
    assign o_almost_full  = (r_count >= AfC);
    assign o_almost_empty = (r_count <= AeC);
    assign o_count        = r_count;
    assign o_free         = DepthC - r_count;
    assign o_high_water   = r_high_water;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_hc_sync_fifo.sv
// Self-checking bench for hc_sync_fifo: constant vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_hc_sync_fifo;

    localparam int unsigned WIDTH = 512;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = 4;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b1;
    logic             flush    = 1'b0;
    logic             enq_en   = 1'b0;
    logic             deq_en   = 1'b0;
    logic [WIDTH-1:0] enq_data = '0;
    logic             not_full, not_empty, almost_full, almost_empty, overflow, underflow;
    logic [WIDTH-1:0] deq_data;
    logic [CW-1:0]    count, free, high_water;

    hc_sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_flush       (flush),
        .i_enq_data    (enq_data),
        .i_enq_en      (enq_en),
        .o_not_full    (not_full),
        .o_deq_data    (deq_data),
        .i_deq_en      (deq_en),
        .o_not_empty   (not_empty),
        .o_almost_full (almost_full),
        .o_almost_empty(almost_empty),
        .o_count       (count),
        .o_free        (free),
        .o_high_water  (high_water),
        .o_overflow    (overflow),
        .o_underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of words plus the tracked statistics.
    logic [WIDTH-1:0] q [$];
    int               m_hw = 0;
    logic             m_ov = 1'b0;
    logic             m_uf = 1'b0;

    typedef struct {
        logic       enq;
        logic       deq;
        logic       fl;
        logic [7:0] data;
        int         ecount;
        int         ehw;
        logic       eov;
        logic       euf;
        logic [7:0] ehead;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic e, input logic d, input logic f, input logic [7:0] dat,
                                input int c, input int hw, input logic ov, input logic uf,
                                input logic [7:0] head);
        vec_t v;
        v.enq = e; v.deq = d; v.fl = f; v.data = dat;
        v.ecount = c; v.ehw = hw; v.eov = ov; v.euf = uf; v.ehead = head;
        tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_hw = 0;
        m_ov = 1'b0;
        m_uf = 1'b0;
    endfunction

    function automatic void model_update(input logic e, input logic d, input logic f,
                                         input logic [WIDTH-1:0] data);
        logic was_full, was_empty;
        logic [WIDTH-1:0] dummy;
        if (f) begin
            model_reset();
            return;
        end
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (e && was_full) m_ov = 1'b1;
        if (d && was_empty) m_uf = 1'b1;
        if (d && !was_empty) dummy = q.pop_front();
        if (e && !was_full) q.push_back(data);
        if (q.size() > m_hw) m_hw = q.size();
    endfunction

    task automatic check_model(input string tag);
        int c;
        c = q.size();
        chk({tag, " count"}, count, c);
        chk({tag, " free"}, free, DEPTH - c);
        chk({tag, " not_full"}, not_full, c < DEPTH);
        chk({tag, " not_empty"}, not_empty, c > 0);
        chk({tag, " almost_full"}, almost_full, c >= AF);
        chk({tag, " almost_empty"}, almost_empty, c <= AE);
        chk({tag, " high_water"}, high_water, m_hw);
        chk({tag, " overflow"}, overflow, m_ov);
        chk({tag, " underflow"}, underflow, m_uf);
        if (c > 0) chk({tag, " deq_data"}, deq_data, q[0]);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic e, input logic d, input logic f,
                        input logic [WIDTH-1:0] data);
        enq_en = e; deq_en = d; flush = f; enq_data = data;
        model_update(e, d, f, data);
        @(posedge clk);
        #1;
        enq_en = 1'b0; deq_en = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic e, d, f;

        // Fill 0..7, overflow, full enq+deq, drain, underflow, empty enq+deq, mid-level enq+deq.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(i), i + 1, i + 1, 0, 0, 8'h00);
        add(1, 0, 0, 8'hAA, 8, 8, 1, 0, 8'h00);
        add(1, 1, 0, 8'hBB, 7, 8, 1, 0, 8'h01);
        for (int k = 2; k < 8; k++) add(0, 1, 0, 8'h00, 8 - k, 8, 1, 0, 8'(k));
        add(0, 1, 0, 8'h00, 0, 8, 1, 0, 8'h00);
        add(0, 1, 0, 8'h00, 0, 8, 1, 1, 8'h00);
        add(1, 1, 0, 8'h33, 1, 8, 1, 1, 8'h33);
        add(1, 0, 0, 8'h44, 2, 8, 1, 1, 8'h33);
        add(1, 1, 0, 8'h55, 2, 8, 1, 1, 8'h44);
        add(1, 1, 0, 8'h66, 2, 8, 1, 1, 8'h55);

        // Power-up reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset count", count, 0);
        chk("reset free", free, DEPTH);
        chk("reset almost_empty", almost_empty, 1'b1);
        check_model("reset");
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v.enq, v.deq, v.fl, WIDTH'(v.data));
            chk($sformatf("vec%0d count", i), count, v.ecount);
            chk($sformatf("vec%0d free", i), free, DEPTH - v.ecount);
            chk($sformatf("vec%0d not_full", i), not_full, v.ecount < DEPTH);
            chk($sformatf("vec%0d almost_full", i), almost_full, v.ecount >= AF);
            chk($sformatf("vec%0d almost_empty", i), almost_empty, v.ecount <= AE);
            chk($sformatf("vec%0d high_water", i), high_water, v.ehw);
            chk($sformatf("vec%0d overflow", i), overflow, v.eov);
            chk($sformatf("vec%0d underflow", i), underflow, v.euf);
            if (v.ecount > 0) chk($sformatf("vec%0d deq_data", i), deq_data, WIDTH'(v.ehead));
        end

        // Flush at count 5 with overflow set, with enq and deq also requested.
        step(0, 0, 1, '0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, WIDTH'(32'h100 + i));
        step(1, 0, 0, WIDTH'(32'hAA));
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        chk("preflush count", count, 5);
        chk("preflush overflow", overflow, 1'b1);
        step(1, 1, 1, WIDTH'(32'hDEAD));
        chk("flush count", count, 0);
        chk("flush high_water", high_water, 0);
        chk("flush overflow", overflow, 1'b0);
        chk("flush not_empty", not_empty, 1'b0);
        step(1, 0, 0, WIDTH'(32'h77));
        chk("postflush deq_data", deq_data, WIDTH'(32'h77));
        chk("postflush count", count, 1);

        // Wrap-around stream of 40 words.
        step(0, 0, 1, '0);
        for (int i = 0; i <= 40; i++) begin
            e = (i < 40);
            d = (i > 0);
            if (d) chk($sformatf("wrap word%0d", i - 1), deq_data, WIDTH'(i - 1));
            step(e, d, 0, WIDTH'(i));
            chk("wrap count<=1", count <= 1, 1'b1);
            check_model("wrap");
        end
        chk("wrap high_water", high_water, 1);

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) step(1, 0, 0, WIDTH'(32'hC0 + i));
        chk("prereset count", count, 3);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async count", count, 0);
        chk("async free", free, DEPTH);
        chk("async not_empty", not_empty, 1'b0);
        check_model("async");
        @(negedge clk) reset_n = 1'b1;
        step(1, 0, 0, WIDTH'(32'h5));
        chk("postreset deq_data", deq_data, WIDTH'(32'h5));
        chk("postreset count", count, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) < 2 + (i / 100) % 2);
            f = ($urandom_range(0, 63) == 0);
            step(e, d, f, rand_word());
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hc_sync_fifo.md
# hc_sync_fifo

Parametrised single-clock FIFO that succeeds the fixed 512x8 loopback buffer and serves as the general buffering primitive between the CCI-P request/response paths and accelerator datapaths. It uses the full configured depth, adds programmable almost-full/almost-empty thresholds, occupancy and free-slot counts, and a high-water mark. It also provides sticky overflow/underflow error flags and a synchronous flush. Dequeue is show-ahead: the head word is presented on `deq_data` whenever `not_empty` is high.

## Interface
- `WIDTH`, 512, data word width in bits (>= 1).
- `DEPTH`, 8, number of entries; power of two, >= 2.
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count >= AF_THRESH (1..DEPTH).
- `AE_THRESH`, 1, `almost_empty` asserts when count <= AE_THRESH (0..DEPTH-1).
- Derived: `CW` = $clog2(DEPTH)+1 (count width); `PW` = $clog2(DEPTH) (pointer width).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents, counters and error flags.
- `enq_data`  in  WIDTH  write data.
- `enq_en`  in  1  enqueue request.
- `not_full`  out  1  high when count < DEPTH.
- `deq_data`  out  WIDTH  head-of-queue word; valid only while `not_empty` = 1.
- `deq_en`  in  1  dequeue request; pops the head word.
- `not_empty`  out  1  high when count > 0.
- `almost_full`  out  1  count >= AF_THRESH.
- `almost_empty`  out  1  count <= AE_THRESH.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `free`  out  CW  DEPTH - count; used as credit count by upstream.
- `high_water`  out  CW  maximum count reached since reset or last flush.
- `overflow`  out  1  sticky: enqueue was attempted while full.
- `underflow`  out  1  sticky: dequeue was attempted while empty.

## Operation
- Enqueue accepted iff `enq_en` && `not_full`. The word is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Dequeue accepted iff `deq_en` && `not_empty`. rd_ptr increments modulo DEPTH.
- `count` next value:
  - +1 when only the enqueue is accepted.
  - -1 when only the dequeue is accepted.
  - Unchanged when both or neither are accepted.
- Acceptance is evaluated against the current-cycle flags:
  - Full + enq + deq: the deq is accepted, the enq is rejected (overflow set), and count becomes DEPTH-1.
  - Empty + enq + deq: the enq is accepted, the deq is rejected (underflow set), and count becomes 1.
- `high_water` <= max(high_water, count_next) every cycle.
- `overflow` sets on `enq_en` && !`not_full`. `underflow` sets on `deq_en` && !`not_empty`. Both hold until flush or reset.
- `flush` has priority over enq/deq in the same cycle. It clears wr_ptr, rd_ptr, count, high_water, overflow and underflow; enq/deq in that cycle are ignored and do not set flags. Memory contents are not cleared.
- `not_full`, `not_empty`, `almost_*` and `free` are combinational decodes of the registered `count`. `deq_data` = mem[rd_ptr], combinational from registered state.
- Memory has no reset; it is written only on an accepted enqueue.

## Timing
- Reset (`reset_n` low) takes effect immediately, not at the next edge.
- Reset values of outputs:
  - count = 0, free = DEPTH, high_water = 0.
  - not_full = 1, not_empty = 0.
  - almost_full = 0, almost_empty = 1.
  - overflow = 0, underflow = 0.
  - deq_data = don't-care.
- Write-to-read latency is 1 cycle. A word accepted at edge N sets `not_empty` and appears on `deq_data` after edge N, and can be dequeued at edge N+1.
- Pop latency is 0. When a dequeue is accepted at edge N, the next word is on `deq_data` after edge N.
- Flag latency: all status outputs reflect accepted operations after the same edge.
- `free` reaches 0 exactly when `not_full` falls. Upstream may issue `free` enqueues without checking `not_full`.
- Pointers wrap from DEPTH-1 to 0 with no bubble. full/empty is resolved by `count`, never by pointer comparison.
- Reset deasserted mid-stream: the FIFO restarts empty, and the first enqueue after release behaves as after power-up.

## Test plan
All scenarios use WIDTH=512, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- **Fill from reset:** enqueue 0..7 on back-to-back edges.
  - After the 8th edge: count=8, free=0, not_full=0, high_water=8.
  - almost_full rises after the 6th edge; almost_empty falls after the 2nd edge.
- **Overflow, then drain:** on a full FIFO, enq_en=1 for 1 cycle with data 0xAA.
  - overflow=1, count stays 8.
  - Draining 8 pops yields 0..7 in order with no 0xAA; then not_empty=0 and overflow is still 1.
- **Simultaneous enq/deq:**
  - At count=4: count stays 4 and order is preserved.
  - At count=8: count becomes 7 and overflow=1.
  - At count=0: count becomes 1, underflow=1, and deq_data equals the enqueued word next cycle.
- **Wrap-around stream:** 40 words, pattern i, with enq every cycle and deq every cycle after the first word.
  - All 40 words are received in order.
  - count never exceeds 1; high_water=1.
- **Flush mid-operation:** at count=5 with overflow=1, assert flush together with enq_en=1 and deq_en=1.
  - Next cycle: count=0, high_water=0, overflow=0, not_empty=0.
  - The concurrent enqueue is not stored.
- **Async reset mid-stream:** drop reset_n between edges at count=3.
  - Outputs take their reset values before the next edge.
  - After release, enqueue 0x5 gives deq_data=0x5 and count=1.
